// File: rtl/calc_ctrl_if.sv
// Key/entry/ALU signal bundle for the calculator sequencing controller.
// master: the controller side; slave: keypad decoder, entry register and ALU side.
interface calc_ctrl_if #(
   parameter int NUM_OPS = 4
);
   localparam int OP_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

   logic            valid_scan_code;
   logic [3:0]      binary_val;
   logic [9:0]      bcd_value;
   logic            alu_done;
   logic            op_ctrl;
   logic [7:0]      operand_a;
   logic [7:0]      operand_b;
   logic [OP_W-1:0] alu_op;
   logic            alu_start;
   logic [2:0]      state_o;
   logic            error;

   modport master (
      input  valid_scan_code, binary_val, bcd_value, alu_done,
      output op_ctrl, operand_a, operand_b, alu_op, alu_start, state_o, error
   );

   modport slave (
      output valid_scan_code, binary_val, bcd_value, alu_done,
      input  op_ctrl, operand_a, operand_b, alu_op, alu_start, state_o, error
   );
endinterface

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: operand A entry, operator select,
// operand B entry, ALU launch with timeout, result display.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ENTER_A  | user keys operand A; ENTER captures it
// ENTER_OP | OPNEXT steps alu_op; ENTER moves on to operand B
// ENTER_B  | user keys operand B; ENTER captures it and launches ALU
// COMPUTE  | waiting for alu_done, bounded by TIMEOUT cycles
// SHOW     | result displayed; ENTER returns to ENTER_A
//
// CLEAR aborts from any state back to ENTER_A with everything zeroed.
module calc_ctrl #(
   parameter int NUM_OPS = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   calc_ctrl_if.master bus
);
   localparam int OP_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [3:0]       KEY_ENTER  = 4'hA;
   localparam logic [3:0]       KEY_OPNEXT = 4'hB;
   localparam logic [3:0]       KEY_CLEAR  = 4'hC;
   localparam logic [OP_W-1:0]  OP_LAST    = OP_W'(NUM_OPS - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ENTER_A  = 3'd0,
      ENTER_OP = 3'd1,
      ENTER_B  = 3'd2,
      COMPUTE  = 3'd3,
      SHOW     = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [7:0]      operand_a, operand_a_nx;
   logic [7:0]      operand_b, operand_b_nx;
   logic [OP_W-1:0] alu_op, alu_op_nx;
   logic            op_ctrl, op_ctrl_nx;
   logic            alu_start, alu_start_nx;
   logic            error, error_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   logic [7:0] bin;
   logic       key_enter, key_opnext, key_clear;

   // BCD entry value to binary; modulo-256 arithmetic gives the 8-bit truncation directly
   always_comb begin
      bin = {6'b0, bus.bcd_value[9:8]} * 8'd100
          + {4'b0, bus.bcd_value[7:4]} * 8'd10
          + {4'b0, bus.bcd_value[3:0]};
   end

   assign key_enter  = bus.valid_scan_code && (bus.binary_val == KEY_ENTER);
   assign key_opnext = bus.valid_scan_code && (bus.binary_val == KEY_OPNEXT);
   assign key_clear  = bus.valid_scan_code && (bus.binary_val == KEY_CLEAR);

   // State and all registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ENTER_A;
         operand_a <= '0;
         operand_b <= '0;
         alu_op    <= '0;
         op_ctrl   <= 1'b0;
         alu_start <= 1'b0;
         error     <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_nx;
         operand_a <= operand_a_nx;
         operand_b <= operand_b_nx;
         alu_op    <= alu_op_nx;
         op_ctrl   <= op_ctrl_nx;
         alu_start <= alu_start_nx;
         error     <= error_nx;
         cnt       <= cnt_nx;
      end
   end

   // Next-state and next-output decode; CLEAR overrides every state
   always_comb begin
      logic clr_req;
      state_nx     = state;
      operand_a_nx = operand_a;
      operand_b_nx = operand_b;
      alu_op_nx    = alu_op;
      alu_start_nx = 1'b0;
      error_nx     = error;
      cnt_nx       = cnt;
      clr_req      = 1'b0;

      if (key_clear) begin
         clr_req      = 1'b1;
         operand_a_nx = '0;
         operand_b_nx = '0;
         alu_op_nx    = '0;
         error_nx     = 1'b0;
         cnt_nx       = '0;
         state_nx     = ENTER_A;
      end else begin
         case (state)
            ENTER_A: begin
               if (key_enter) begin
                  operand_a_nx = bin;
                  clr_req      = 1'b1;
                  state_nx     = ENTER_OP;
               end
            end
            ENTER_OP: begin
               if (key_opnext) begin
                  alu_op_nx = (alu_op == OP_LAST) ? '0 : alu_op + 1'b1;
               end else if (key_enter) begin
                  clr_req  = 1'b1;
                  state_nx = ENTER_B;
               end
            end
            ENTER_B: begin
               if (key_enter) begin
                  operand_b_nx = bin;
                  alu_start_nx = 1'b1;
                  error_nx     = 1'b0;
                  cnt_nx       = '0;
                  state_nx     = COMPUTE;
               end
            end
            COMPUTE: begin
               if (bus.alu_done) begin
                  error_nx = 1'b0;
                  state_nx = SHOW;
               end else if (cnt == CNT_LIMIT) begin
                  error_nx = 1'b1;
                  state_nx = SHOW;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            SHOW: begin
               if (key_enter) begin
                  clr_req  = 1'b1;
                  state_nx = ENTER_A;
               end
            end
            default: begin
               state_nx = ENTER_A;
            end
         endcase
      end

      // back-to-back strobes would otherwise stretch the clear pulse; the entry
      // register was cleared the cycle before, so dropping the repeat loses nothing
      op_ctrl_nx = clr_req && !op_ctrl;
   end

   assign bus.op_ctrl   = op_ctrl;
   assign bus.operand_a = operand_a;
   assign bus.operand_b = operand_b;
   assign bus.alu_op    = alu_op;
   assign bus.alu_start = alu_start;
   assign bus.state_o   = state;
   assign bus.error     = error;
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: vector table for the main flow plus
// hand sequences for timeout, done-at-limit, CLEAR abort and async reset.
module tb_calc_ctrl;
   logic clk;
   logic rst;

   calc_ctrl_if #(.NUM_OPS(4)) bus ();

   calc_ctrl #(.NUM_OPS(4), .TIMEOUT(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic       v;
      logic [3:0] key;
      logic [9:0] bcd;
      logic       done;
      int         st;
      int         a;
      int         b;
      int         op;
      int         oc;
      int         as;
      int         er;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [3:0] key, input logic [9:0] bcd,
                               input logic done, input int st, input int a, input int b,
                               input int op, input int oc, input int as, input int er);
      vec_t r;
      r.v = v; r.key = key; r.bcd = bcd; r.done = done;
      r.st = st; r.a = a; r.b = b; r.op = op; r.oc = oc; r.as = as; r.er = er;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic press(input logic [3:0] k, input logic [9:0] bcd);
      bus.valid_scan_code = 1'b1;
      bus.binary_val      = k;
      bus.bcd_value       = bcd;
      @(negedge clk);
      bus.valid_scan_code = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // ENTER A, ENTER operator, ENTER B with spacer cycles; ends in COMPUTE, counter 0
   task automatic goto_compute(input logic [9:0] a_bcd, input logic [9:0] b_bcd);
      press(4'hA, a_bcd);
      idle(1);
      press(4'hA, 10'h000);
      idle(1);
      press(4'hA, b_bcd);
   endtask

   task automatic wait_leave_compute(output int n);
      n = 0;
      while (bus.state_o == 3'd3 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      rst                 = 1'b0;
      bus.valid_scan_code = 1'b0;
      bus.binary_val      = 4'h0;
      bus.bcd_value       = 10'h000;
      bus.alu_done        = 1'b0;

      vecs.push_back(mk(1, 4'h1, 10'h001, 0, 0,   0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4'h2, 10'h012, 0, 0,   0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4'h3, 10'h123, 0, 0,   0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4'hB, 10'h123, 0, 0,   0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4'hE, 10'h012, 0, 0,   0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4'hA, 10'h123, 0, 1, 123,   0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h000, 0, 1, 123,   0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4'hB, 10'h000, 0, 1, 123,   0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 4'hB, 10'h000, 0, 1, 123,   0, 2, 0, 0, 0));
      vecs.push_back(mk(1, 4'hB, 10'h000, 0, 1, 123,   0, 3, 0, 0, 0));
      vecs.push_back(mk(1, 4'hB, 10'h000, 0, 1, 123,   0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4'hB, 10'h000, 0, 1, 123,   0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 4'hD, 10'h000, 0, 1, 123,   0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 4'hA, 10'h000, 0, 2, 123,   0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h255, 0, 2, 123,   0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 4'hB, 10'h255, 0, 2, 123,   0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 4'hA, 10'h255, 0, 3, 123, 255, 1, 0, 1, 0));
      vecs.push_back(mk(0, 4'h0, 10'h255, 0, 3, 123, 255, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h255, 0, 3, 123, 255, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h255, 0, 3, 123, 255, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h255, 0, 3, 123, 255, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h255, 1, 4, 123, 255, 1, 0, 0, 0));
      vecs.push_back(mk(1, 4'hF, 10'h000, 0, 4, 123, 255, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h000, 1, 4, 123, 255, 1, 0, 0, 0));
      vecs.push_back(mk(1, 4'hA, 10'h000, 0, 0, 123, 255, 1, 1, 0, 0));
      vecs.push_back(mk(0, 4'h0, 10'h000, 1, 0, 123, 255, 1, 0, 0, 0));

      // reset values
      idle(3);
      chk("rst_state", bus.state_o, 0);
      chk("rst_a", bus.operand_a, 0);
      chk("rst_b", bus.operand_b, 0);
      chk("rst_op", bus.alu_op, 0);
      chk("rst_opctrl", bus.op_ctrl, 0);
      chk("rst_start", bus.alu_start, 0);
      chk("rst_err", bus.error, 0);
      rst = 1'b1;
      idle(2);

      // main flow table
      for (int i = 0; i < vecs.size(); i++) begin
         bus.valid_scan_code = vecs[i].v;
         bus.binary_val      = vecs[i].key;
         bus.bcd_value       = vecs[i].bcd;
         bus.alu_done        = vecs[i].done;
         @(negedge clk);
         chk($sformatf("v%0d_state", i), bus.state_o, vecs[i].st);
         chk($sformatf("v%0d_a", i), bus.operand_a, vecs[i].a);
         chk($sformatf("v%0d_b", i), bus.operand_b, vecs[i].b);
         chk($sformatf("v%0d_op", i), bus.alu_op, vecs[i].op);
         chk($sformatf("v%0d_opctrl", i), bus.op_ctrl, vecs[i].oc);
         chk($sformatf("v%0d_start", i), bus.alu_start, vecs[i].as);
         chk($sformatf("v%0d_err", i), bus.error, vecs[i].er);
      end
      bus.valid_scan_code = 1'b0;
      bus.alu_done        = 1'b0;
      idle(1);

      // timeout with no alu_done
      goto_compute(10'h199, 10'h007);
      chk("to_a", bus.operand_a, 199);
      chk("to_b", bus.operand_b, 7);
      chk("to_start", bus.alu_start, 1);
      chk("to_state", bus.state_o, 3);
      wait_leave_compute(n);
      chk("to_cycles", n, 64);
      chk("to_show", bus.state_o, 4);
      chk("to_err", bus.error, 1);
      idle(2);
      chk("to_err_sticky", bus.error, 1);
      press(4'hA, 10'h000);
      chk("to_back_state", bus.state_o, 0);
      chk("to_back_opctrl", bus.op_ctrl, 1);
      chk("to_back_err", bus.error, 1);
      idle(1);

      // alu_done exactly on the limit cycle
      goto_compute(10'h100, 10'h050);
      chk("lim_err_cleared", bus.error, 0);
      chk("lim_a", bus.operand_a, 100);
      chk("lim_b", bus.operand_b, 50);
      idle(63);
      chk("lim_still_compute", bus.state_o, 3);
      bus.alu_done = 1'b1;
      @(negedge clk);
      bus.alu_done = 1'b0;
      chk("lim_show", bus.state_o, 4);
      chk("lim_err", bus.error, 0);
      press(4'hA, 10'h000);
      idle(1);

      // timeout then CLEAR from SHOW
      goto_compute(10'h000, 10'h001);
      idle(64);
      chk("to2_show", bus.state_o, 4);
      chk("to2_err", bus.error, 1);
      press(4'hC, 10'h000);
      chk("clr_show_err", bus.error, 0);
      chk("clr_show_state", bus.state_o, 0);
      chk("clr_show_opctrl", bus.op_ctrl, 1);
      chk("clr_show_op", bus.alu_op, 0);
      idle(1);
      chk("clr_show_opctrl_low", bus.op_ctrl, 0);

      // CLEAR mid-compute, late alu_done ignored
      goto_compute(10'h008, 10'h009);
      idle(10);
      chk("abort_in_compute", bus.state_o, 3);
      press(4'hC, 10'h000);
      chk("abort_state", bus.state_o, 0);
      chk("abort_a", bus.operand_a, 0);
      chk("abort_b", bus.operand_b, 0);
      chk("abort_opctrl", bus.op_ctrl, 1);
      bus.alu_done = 1'b1;
      @(negedge clk);
      bus.alu_done = 1'b0;
      chk("abort_late_done_state", bus.state_o, 0);
      chk("abort_opctrl_low", bus.op_ctrl, 0);
      idle(1);

      // async reset in ENTER_OP with alu_op=2
      press(4'hA, 10'h045);
      idle(1);
      press(4'hB, 10'h000);
      press(4'hB, 10'h000);
      chk("pre_rst_state", bus.state_o, 1);
      chk("pre_rst_a", bus.operand_a, 45);
      chk("pre_rst_op", bus.alu_op, 2);
      rst = 1'b0;
      #1;
      chk("arst_state", bus.state_o, 0);
      chk("arst_a", bus.operand_a, 0);
      chk("arst_op", bus.alu_op, 0);
      chk("arst_opctrl", bus.op_ctrl, 0);
      chk("arst_err", bus.error, 0);
      idle(2);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rel%0d_state", i), bus.state_o, 0);
         chk($sformatf("rel%0d_opctrl", i), bus.op_ctrl, 0);
         chk($sformatf("rel%0d_start", i), bus.alu_start, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
